counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 106 ++++++++++
 tb/tb_counter_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Up/down terminal counter with a four-state IDLE/RUN/PAUSE/DONE controller.
// Configuration (limit, mode, dir) is writable only while not counting.
module counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             idle
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic             r_dir;

  logic [WIDTH-1:0] w_start_val;
  logic [WIDTH-1:0] w_term_val;
  logic             w_at_term;
  logic             w_cfg_open;

  assign w_start_val = r_dir ? r_limit : ZERO;
  assign w_term_val  = r_dir ? ZERO : r_limit;
  assign w_at_term   = (r_count == w_term_val);
  assign w_cfg_open  = (r_state == S_IDLE) || (r_state == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_limit <= '1;
      r_mode  <= 1'b0;
      r_dir   <= 1'b0;
    end else if (cfg_we && w_cfg_open) begin
      r_limit <= cfg_limit;
      r_mode  <= cfg_mode;
      r_dir   <= cfg_dir;
    end
  end

  // Terminal check precedes the step, so the count never wraps past 0..limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_count <= ZERO;
    end else if (stop) begin
      r_state <= S_IDLE;
      r_count <= ZERO;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_count <= w_start_val;
          end
        end
        S_RUN: begin
          if (pause) begin
            r_state <= S_PAUSE;
          end else if (w_at_term) begin
            if (r_mode) begin
              r_count <= w_start_val;
            end else begin
              r_state <= S_DONE;
            end
          end else if (r_dir) begin
            r_count <= r_count - ONE;
          end else begin
            r_count <= r_count + ONE;
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= ZERO;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign idle  = (r_state == S_IDLE);
  assign done  = (r_state == S_RUN) && w_at_term;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: expected {count,busy,done,idle} pushed to a
// scoreboard as each step is driven, popped and compared after the edge.
module tb_counter_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start, stop, pause, cfg_we, cfg_mode, cfg_dir;
  logic [W-1:0] cfg_limit;
  logic [W-1:0] count;
  logic         busy, done, idle;

  int checks = 0;
  int errors = 0;

  logic [W+2:0] exp_q[$];
  string        tag_q[$];

  counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
    .cfg_we(cfg_we), .cfg_limit(cfg_limit), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
    .count(count), .busy(busy), .done(done), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [W-1:0] c, input logic b,
                      input logic d, input logic i);
    exp_q.push_back({c, b, d, i});
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    logic [W+2:0] exp_v;
    logic [W+2:0] obs_v;
    string        tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed no expectation, required one queued");
      return;
    end
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_v = {count, busy, done, idle};
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed count=%0d busy=%b done=%b idle=%b, expected count=%0d busy=%b done=%b idle=%b",
             tag, obs_v[W+2:3], obs_v[2], obs_v[1], obs_v[0],
             exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // Advance one edge with the inputs already driven, then check.
  task automatic tick();
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; start = 0; stop = 0; pause = 0;
    cfg_we = 0; cfg_limit = '0; cfg_mode = 0; cfg_dir = 0;
    #12;
    push("reset_state", 0, 0, 0, 1);
    compare();
    @(negedge clk);
    rstn = 1'b1;

    // Default config after reset: up to 15, one-shot.
    start = 1;
    push("def_start", 0, 1, 0, 0);
    tick();
    start = 0;
    for (int i = 1; i <= 15; i++) begin
      push("def_count", W'(i), 1, (i == 15), 0);
      tick();
    end
    push("def_done_hold", 15, 0, 0, 0);
    tick();

    // Down, auto-reload, limit 5; config written while in DONE.
    cfg_we = 1; cfg_limit = 5; cfg_mode = 1; cfg_dir = 1;
    push("cfg_in_done", 15, 0, 0, 0);
    tick();
    cfg_we = 0; start = 1;
    push("down_start", 5, 1, 0, 0);
    tick();
    start = 0;
    for (int k = 1; k <= 13; k++) begin
      push("down_reload", W'(5 - (k % 6)), 1, ((k % 6) == 5), 0);
      tick();
    end
    stop = 1;
    push("stop_in_run", 0, 0, 0, 1);
    tick();
    stop = 0;

    // Up, limit 9, pause at count 4 for three cycles.
    cfg_we = 1; cfg_limit = 9; cfg_mode = 0; cfg_dir = 0;
    push("cfg_in_idle", 0, 0, 0, 1);
    tick();
    cfg_we = 0; start = 1;
    push("up9_start", 0, 1, 0, 0);
    tick();
    start = 0;
    for (int i = 1; i <= 4; i++) begin
      push("up9_count", W'(i), 1, 0, 0);
      tick();
    end
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      push("pause_hold", 4, 1, 0, 0);
      tick();
    end
    pause = 0;
    push("pause_release", 4, 1, 0, 0);
    tick();
    for (int i = 5; i <= 9; i++) begin
      push("up9_resume", W'(i), 1, (i == 9), 0);
      tick();
    end
    push("up9_done", 9, 0, 0, 0);
    tick();

    // cfg write and start during RUN are ignored.
    start = 1;
    push("restart_from_done", 0, 1, 0, 0);
    tick();
    start = 0; cfg_we = 1; cfg_limit = 2; cfg_mode = 1; cfg_dir = 1;
    push("cfg_in_run_ignored", 1, 1, 0, 0);
    tick();
    cfg_we = 0; start = 1;
    push("start_in_run_ignored", 2, 1, 0, 0);
    tick();
    start = 0;
    for (int i = 3; i <= 9; i++) begin
      push("old_limit_count", W'(i), 1, (i == 9), 0);
      tick();
    end
    push("old_limit_done", 9, 0, 0, 0);
    tick();
    start = 1; stop = 1;
    push("start_and_stop", 0, 0, 0, 1);
    tick();
    stop = 0;

    // Asynchronous reset mid-count at 7.
    push("run_for_reset", 0, 1, 0, 0);
    tick();
    start = 0;
    for (int i = 1; i <= 7; i++) begin
      push("pre_reset_count", W'(i), 1, 0, 0);
      tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    push("async_reset", 0, 0, 0, 1);
    compare();
    push("reset_held", 0, 0, 0, 1);
    tick();
    rstn = 1'b1;
    push("post_reset_idle", 0, 0, 0, 1);
    tick();

    // limit 0, auto-reload: done continuously high.
    cfg_we = 1; cfg_limit = 0; cfg_mode = 1; cfg_dir = 0;
    push("cfg_limit0", 0, 0, 0, 1);
    tick();
    cfg_we = 0; start = 1;
    push("limit0_start", 0, 1, 1, 0);
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      push("limit0_reload", 0, 1, 1, 0);
      tick();
    end
    stop = 1;
    push("limit0_stop", 0, 0, 0, 1);
    tick();
    stop = 0;

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
